riscv_core_dpath_load_resp_queue: RTL and testbench
===================================================

# riscv_core_dpath_load_resp_queue

Parametrised, in-order load-response buffer for the RISC-V datapath, replacing the single-entry data-memory response register in the M stage. It reserves a slot per issued load (carrying load type and byte offset), captures the memory response without back-pressure, performs address-aligned subword extraction and sign/zero extension, and delivers results in issue order over a val/rdy interface. An empty-queue bypass gives zero added latency, and unexpected responses are flagged.

## Interface
- `DEPTH`, 4, number of outstanding loads; power of two, ≥ 2.
- `PTR_W`, `$clog2(DEPTH)`, pointer width; derived, not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_val`  in  1  load issued in X; reserve a slot.
- `req_rdy`  out  1  slot available: `count < DEPTH`.
- `req_fn`  in  3  0=lw, 1=lb, 2=lbu, 3=lh, 4=lhu; 5–7 are treated as lw.
- `req_offset`  in  2  byte address bits [1:0] of the load.
- `memresp_val`  in  1  memory response valid; never back-pressured.
- `memresp_data`  in  32  raw word from memory.
- `deq_val`  out  1  oldest load result available.
- `deq_rdy`  in  1  consumer (writeback mux) accepts the result.
- `deq_data`  out  32  aligned, extended result.
- `count`  out  PTR_W+1  reserved slots, i.e. loads issued but not yet dequeued.
- `err_unexp`  out  1  sticky: a response arrived with no pending load.

## Operation
- Storage: DEPTH entries of {fn[2:0], offset[1:0], data[31:0], dvalid}. There are three PTR_W+1-bit pointers (the extra bit distinguishes full from empty):
  - `tail`: next slot to reserve.
  - `rptr`: next slot awaiting a response.
  - `head`: oldest slot to dequeue.
- Invariant: head ≤ rptr ≤ tail, modulo 2^(PTR_W+1). `count = tail − head`.
- Reserve: on `req_val && req_rdy`, write fn/offset at `tail[PTR_W-1:0]`, clear dvalid, and increment `tail`.
- Response: on `memresp_val` with `rptr != tail`, align the data using the tag at `rptr` and increment `rptr`. If that entry is bypassed this cycle, no write occurs; otherwise write the aligned data and set dvalid.
- Unexpected response: `memresp_val` with `rptr == tail` drops the data and sets `err_unexp`. The flag clears only on reset.
- Alignment:
  - lw: the raw word.
  - lb/lbu: byte `memresp_data[8*offset +: 8]`, sign- or zero-extended.
  - lh/lhu: half `memresp_data[16*offset[1] +: 16]`, sign- or zero-extended; `offset[0]` is ignored.
- Dequeue:
  - `deq_val = dvalid[head] || bypass`.
  - `bypass = (head == rptr) && (head != tail) && memresp_val`.
  - `deq_data` is the stored data when dvalid is set, otherwise the aligned response.
  - On `deq_val && deq_rdy`, increment `head` and clear dvalid.
- Ordering: results leave strictly in reservation order. There is no reordering and no flush.

## Timing
- Reset values: `head = rptr = tail = 0`, all dvalid = 0, `count = 0`, `req_rdy = 1`, `deq_val = 0`, `deq_data` undefined (X permitted), `err_unexp = 0`.
- Reset mid-operation: all pending loads are discarded immediately (asynchronous). Responses that arrive after reset deassertion flag `err_unexp`; the controller must not assert reset with loads in flight unless memory is also reset.
- Latency:
  - Bypass: 0 cycles, from response to `deq_val` in the same cycle.
  - Stored entry: visible on `deq_val` the cycle after capture.
- Paths: `req_rdy` depends only on registered `count`. There is no full-queue enqueue+dequeue pass-through; a dequeue frees a slot for the next cycle.
- Combinational paths: `deq_val`/`deq_data` have a combinational path from `memresp_val`/`memresp_data` through the bypass. There is no combinational path from `deq_rdy` to `req_rdy`.
- Simultaneous events: reserve, response and dequeue may all fire in one cycle, and each pointer updates independently. `count` changes by +1, −1 or 0.
- Full: with `count == DEPTH`, `req_rdy = 0` and `req_val` is ignored. Responses are still accepted, because every pending response already owns a slot.
- Wrap-around: pointers increment modulo 2^(PTR_W+1), and indices use the low PTR_W bits.
- Bypass with `deq_rdy = 0`: the response is written to the entry and dvalid is set. The same value is held on `deq_data` in the next cycle.

## Test plan
- Bypass lb: reserve fn=1, offset=2; next cycle respond 0x12_84_56_78 with `deq_rdy=1` → same cycle `deq_val=1`, `deq_data=0xFFFFFF84`; `count` returns 1→0.
- Subword matrix: for each fn 0–4 × offset 0–3, respond 0x8899AABB → check against a reference model. Examples: lhu offset=2 → 0x00008899; lh offset=1 → 0xFFFFAABB.
- Fill and stall: with DEPTH=4 and `deq_rdy=0`, reserve 4 loads → `req_rdy=0` and a 5th `req_val` is ignored. Respond with 1, 2, 3, 4, then raise `deq_rdy` → dequeued 1, 2, 3, 4 on consecutive cycles; `req_rdy=1` the cycle after the first dequeue.
- Simultaneous traffic: hold `count=2` while reserving, responding and dequeuing every cycle for 20 cycles → order preserved, `count` stays 2, and pointers wrap without error.
- Unexpected response: `memresp_val` with `count=0` → `deq_val=0` and `err_unexp=1` from the next cycle onward, persisting until reset.
- Async reset: with 3 pending loads, assert `reset=0` mid-cycle → immediately `count=0`, `req_rdy=1`, `deq_val=0`, `err_unexp=0`.

Source files
------------

// File: rtl/riscv_core_dpath_load_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_dpath_load_resp_queue
// Purpose  : In-order load-response buffer for the M stage. Reserves a slot
//            per issued load, captures memory responses without back-pressure,
//            aligns/extends subword loads and delivers results in issue order.
//            An empty-queue bypass gives zero added latency.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_dpath_load_resp_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active-low
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [1:0]       req_offset,
  input  logic             memresp_val,
  input  logic [31:0]      memresp_data,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [31:0]      deq_data,
  output logic [PTR_W:0]   count,
  output logic             err_unexp
);

  localparam logic [PTR_W:0] C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_PTR_ONE = (PTR_W+1)'(1);

  // Pointers carry one extra bit so full and empty are distinguishable
  logic [PTR_W:0]   tail_q, tail_d;
  logic [PTR_W:0]   rptr_q, rptr_d;
  logic [PTR_W:0]   head_q, head_d;
  logic [2:0]       fn_q   [DEPTH];
  logic [2:0]       fn_d   [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic [1:0]       off_d  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] dvalid_q, dvalid_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] tail_idx, rptr_idx, head_idx;
  logic             req_fire, resp_pending, resp_hit, bypass, deq_fire;
  logic [2:0]       resp_fn;
  logic [1:0]       resp_off;
  logic [7:0]       resp_byte;
  logic [15:0]      resp_half;
  logic [31:0]      resp_aligned;

  assign tail_idx     = tail_q[PTR_W-1:0];
  assign rptr_idx     = rptr_q[PTR_W-1:0];
  assign head_idx     = head_q[PTR_W-1:0];

  assign count        = tail_q - head_q;
  assign req_rdy      = (count != C_DEPTH);
  assign req_fire     = req_val && req_rdy;
  assign resp_pending = (rptr_q != tail_q);
  assign resp_hit     = memresp_val && resp_pending;
  // The oldest load is still waiting for its data and it is arriving now
  assign bypass       = (head_q == rptr_q) && (head_q != tail_q) && memresp_val;
  assign deq_val      = dvalid_q[head_idx] || bypass;
  assign deq_data     = dvalid_q[head_idx] ? data_q[head_idx] : resp_aligned;
  assign deq_fire     = deq_val && deq_rdy;
  assign err_unexp    = err_q;

  // Align and extend the incoming word using the tag of the slot it answers
  always_comb begin
    resp_fn   = fn_q[rptr_idx];
    resp_off  = off_q[rptr_idx];
    resp_byte = memresp_data[{resp_off, 3'b000} +: 8];
    resp_half = resp_off[1] ? memresp_data[31:16] : memresp_data[15:0];
    case (resp_fn)
      3'd1:    resp_aligned = {{24{resp_byte[7]}}, resp_byte};
      3'd2:    resp_aligned = {24'd0, resp_byte};
      3'd3:    resp_aligned = {{16{resp_half[15]}}, resp_half};
      3'd4:    resp_aligned = {16'd0, resp_half};
      default: resp_aligned = memresp_data;  // lw and unused encodings
    endcase
  end

  // Next-state for pointers, slot storage and the sticky error flag
  always_comb begin
    tail_d   = tail_q;
    rptr_d   = rptr_q;
    head_d   = head_q;
    fn_d     = fn_q;
    off_d    = off_q;
    data_d   = data_q;
    dvalid_d = dvalid_q;
    err_d    = err_q;

    if (req_fire) begin
      fn_d[tail_idx]     = req_fn;
      off_d[tail_idx]    = req_offset;
      dvalid_d[tail_idx] = 1'b0;
      tail_d             = tail_q + C_PTR_ONE;
    end

    if (deq_fire) begin
      dvalid_d[head_idx] = 1'b0;
      head_d             = head_q + C_PTR_ONE;
    end

    // A bypassed response consumed this cycle never needs to be stored;
    // if the consumer stalls it is kept so it is presented again next cycle.
    if (resp_hit) begin
      rptr_d = rptr_q + C_PTR_ONE;
      if (!(bypass && deq_rdy)) begin
        data_d[rptr_idx]   = resp_aligned;
        dvalid_d[rptr_idx] = 1'b1;
      end
    end

    if (memresp_val && !resp_pending) begin
      err_d = 1'b1;
    end
  end

  // State register; reset discards every pending load immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail_q   <= '0;
      rptr_q   <= '0;
      head_q   <= '0;
      dvalid_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fn_q[i]   <= '0;
        off_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      tail_q   <= tail_d;
      rptr_q   <= rptr_d;
      head_q   <= head_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      fn_q     <= fn_d;
      off_q    <= off_d;
      data_q   <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_dpath_load_resp_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_dpath_load_resp_queue
// Purpose  : Scoreboard bench for the load-response queue. Stimulus pushes
//            expected aligned results into a queue; a monitor pops and
//            compares them whenever a result is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core_dpath_load_resp_queue;

  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          req_val;
  logic          req_rdy;
  logic [2:0]    req_fn;
  logic [1:0]    req_offset;
  logic          memresp_val;
  logic [31:0]   memresp_data;
  logic          deq_val;
  logic          deq_rdy;
  logic [31:0]   deq_data;
  logic [PW:0]   count;
  logic          err_unexp;

  riscv_core_dpath_load_resp_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_fn       (req_fn),
    .req_offset   (req_offset),
    .memresp_val  (memresp_val),
    .memresp_data (memresp_data),
    .deq_val      (deq_val),
    .deq_rdy      (deq_rdy),
    .deq_data     (deq_data),
    .count        (count),
    .err_unexp    (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] fn;
    logic [1:0] off;
  } tag_t;

  int          checks = 0;
  int          errors = 0;
  tag_t        pend_q[$];      // reserved loads still waiting for data
  logic [31:0] exp_q[$];       // responded loads waiting to be dequeued
  int          m_count = 0;
  bit          m_err = 1'b0;
  bit          mon_en = 1'b0;
  bit          resp_unexp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference alignment using shifts and arithmetic on the whole word
  function automatic logic [31:0] ref_load(input int unsigned fn, input int unsigned off,
                                           input int unsigned w);
    int unsigned b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (fn)
      1:       return (b >= 128) ? b - 256 : b;
      2:       return b;
      3:       return (h >= 32768) ? h - 65536 : h;
      4:       return h;
      default: return w;
    endcase
  endfunction

  // Drive one cycle of inputs just after the rising edge
  task automatic drive(input bit rv, input logic [2:0] fn, input logic [1:0] off,
                       input bit mv, input logic [31:0] md, input bit dr);
    tag_t t;
    @(posedge clk);
    #1;
    req_val      = rv;
    req_fn       = fn;
    req_offset   = off;
    deq_rdy      = dr;
    memresp_data = md;
    resp_unexp   = 1'b0;
    if (mv) begin
      if (pend_q.size() > 0) begin
        t = pend_q.pop_front();
        exp_q.push_back(ref_load(t.fn, t.off, md));
      end else begin
        resp_unexp = 1'b1;
      end
    end
    memresp_val = mv;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_count > 0 || pend_q.size() > 0) && n < 200) begin
      drive(1'b0, 3'd0, 2'd0, pend_q.size() > 0, $urandom, 1'b1);
      n++;
    end
    drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b1);
    checks++;
    if (m_count != 0) begin
      errors++;
      $display("FAIL drain: %0d loads still outstanding after %0d cycles", m_count, n);
    end
  endtask

  // Monitor: checks registered state and pops the scoreboard on each accept
  initial begin
    bit acc, fire, unexp;
    tag_t t;
    forever begin
      @(negedge clk);
      acc = 1'b0; fire = 1'b0; unexp = 1'b0;
      if (mon_en) begin
        chk("count", 32'(count), m_count);
        chk("req_rdy", 32'(req_rdy), 32'(m_count < DEPTH));
        chk("deq_val", 32'(deq_val), 32'(exp_q.size() > 0));
        chk("err_unexp", 32'(err_unexp), 32'(m_err));
        acc = req_val && (m_count < DEPTH);
        if (acc) begin
          t.fn  = req_fn;
          t.off = req_offset;
          pend_q.push_back(t);
        end
        if (deq_rdy && exp_q.size() > 0) begin
          fire = 1'b1;
          chk("deq_data", deq_data, exp_q.pop_front());
        end
        unexp = memresp_val && resp_unexp;
      end
      @(posedge clk);
      if (mon_en) begin
        m_count = m_count + int'(acc) - int'(fire);
        if (unexp) m_err = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; req_val = 1'b0; req_fn = '0; req_offset = '0;
    memresp_val = 1'b0; memresp_data = '0; deq_rdy = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    chk("rst_deq_val", 32'(deq_val), 32'd0);
    chk("rst_err", 32'(err_unexp), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b0);
    mon_en = 1'b1;

    // Bypass lb: response delivered in the same cycle it arrives
    drive(1'b1, 3'd1, 2'd2, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 3'd0, 2'd0, 1'b1, 32'h1284_5678, 1'b1);
    #1;
    chk("bypass_val", 32'(deq_val), 32'd1);
    chk("bypass_data", deq_data, 32'hFFFF_FF84);
    drain();

    // Subword matrix
    for (int fn = 0; fn < 5; fn++) begin
      for (int off = 0; off < 4; off++) begin
        drive(1'b1, 3'(fn), 2'(off), 1'b0, 32'd0, 1'b1);
        drive(1'b0, 3'd0, 2'd0, 1'b1, 32'h8899_AABB, 1'b1);
        #1;
        if (fn == 4 && off == 2) chk("lhu_off2", deq_data, 32'h0000_8899);
        if (fn == 3 && off == 1) chk("lh_off1", deq_data, 32'hFFFF_AABB);
      end
    end
    drain();

    // Fill and stall: fifth request ignored, results in order afterwards
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd0, 2'(i), 1'b0, 32'd0, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b0, 3'd0, 2'd0, 1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b1);
    drain();

    // Simultaneous reserve/respond/dequeue with count held at 2
    drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom), 1'b0, 32'd0, 1'b1);
    drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom), 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 20; i++)
      drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom), 1'b1, $urandom, 1'b1);
    drain();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      bit mv;
      mv = (pend_q.size() > 0) && ($urandom_range(0, 2) != 0);
      drive(1'($urandom), 3'($urandom_range(0, 7)), 2'($urandom), mv, $urandom,
            1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Unexpected response on an empty queue
    drive(1'b0, 3'd0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    #1;
    chk("unexp_deq_val", 32'(deq_val), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b1);

    // Asynchronous reset with three loads pending
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd2, 2'd1, 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    mon_en = 1'b0;
    req_val = 1'b0; memresp_val = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_req_rdy", 32'(req_rdy), 32'd1);
    chk("arst_deq_val", 32'(deq_val), 32'd0);
    chk("arst_err", 32'(err_unexp), 32'd0);
    pend_q.delete(); exp_q.delete();
    m_count = 0; m_err = 1'b0; resp_unexp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b1);
    mon_en = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 3'd4, 2'd2, 1'b0, 32'd0, 1'b1);
    drive(1'b0, 3'd0, 2'd0, 1'b1, 32'h8899_AABB, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
